// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (LSB first, idle-high), byte strobe plus framing-error strobe.
// Latency: 2-cycle input synchronizer; valid_o/frame_err_o pulse the cycle after the mid-stop sample.
// Backpressure: none -- consumer must capture data_o on valid_o; a new byte simply overwrites it.
// Optional: define UART_RX_MAJORITY_EN to take each mid-bit sample as a 3-sample majority vote.
module uart_rx #(
    parameter int CLOCKS_PER_BAUD = 104
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int CW = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_ferr;

    logic            w_rx_s;
    logic            w_bit;
    logic            w_sample;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Previous two rx_s values, so the vote spans t-2, t-1 and t with no added latency
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    assign w_sample = (r_cnt == '0);

    // Receive FSM: start qualification, 8 data bits, stop check and break hold-off
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Start detection always uses the plain synchronized line
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (w_sample) begin
                        if (w_bit) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                            r_cnt   <= FULL_LOAD;
                            r_idx   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_shift <= {w_bit, r_shift[7:1]};
                        r_cnt   <= FULL_LOAD;
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop gives half a bit of margin for a back-to-back start
                    if (w_sample) begin
                        if (w_bit) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_BREAK: begin
                    // Wait out a held-low line so it reports a single framing error
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_ferr;
    assign busy_o      = (r_state != S_IDLE);

endmodule
